// File: rtl/fpnew_pkg.sv
// Shared FPnew types used by the HUB slice output path.
// Only the IEEE status flag bundle is needed here.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_hub_slice_out_buffer.sv
// Output decoupling FIFO behind a combinational HUB slice: registered valid/ready
// on both sides plus a sticky accumulation of the status flags of every popped result.
module fpnew_hub_slice_out_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] result_i,
  input  status_t          status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output status_t          status_acc_o,
  input  logic             clear_status_i,
  output logic             busy_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext;
    TagType           tag;
  } entry_t;

  entry_t              storage_q [Depth];
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  status_t             status_acc_q, status_acc_d;
  logic                push, pop;
  entry_t              head;

  // Pointers wrap at Depth-1 so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] incPtr(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign in_ready_o  = (count_q != FullCnt);
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Head payload is forced to zero while nothing is stored.
  assign head            = out_valid_o ? storage_q[rd_ptr_q] : '0;
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext;
  assign tag_o           = head.tag;
  assign status_acc_o    = status_acc_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    status_acc_d = (clear_status_i ? status_t'('0) : status_acc_q)
                 | (pop ? head.status : status_t'('0));
    if (pop)  rd_ptr_d = incPtr(rd_ptr_q);
    if (push) wr_ptr_d = incPtr(wr_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
    // A flush still lets a same-cycle pop contribute its flags.
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      status_acc_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      status_acc_q <= status_acc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      storage_q[wr_ptr_q] <= '{result: result_i, status: status_i,
                               ext: extension_bit_i, tag: tag_i};
    end
  end

endmodule

// File: tb/tb_fpnew_hub_slice_out_buffer.sv
// Randomised and directed bench for the HUB slice output buffer, checked against a
// queue-based model of the FIFO and its sticky status accumulator.
module tb_fpnew_hub_slice_out_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] resultIn = '0;
  logic [4:0]  statusIn = '0;
  logic        extIn = 1'b0;
  logic [3:0]  tagIn = '0;
  logic        flush = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] resultOut;
  logic [4:0]  statusOut;
  logic        extOut;
  logic [3:0]  tagOut;
  logic [4:0]  statusAcc;
  logic        clearStatus = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fpnew_hub_slice_out_buffer #(
    .Width  (32),
    .Depth  (DEPTH),
    .TagType(logic [3:0])
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .result_i       (resultIn),
    .status_i       (statusIn),
    .extension_bit_i(extIn),
    .tag_i          (tagIn),
    .flush_i        (flush),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .result_o       (resultOut),
    .status_o       (statusOut),
    .extension_bit_o(extOut),
    .tag_o          (tagOut),
    .status_acc_o   (statusAcc),
    .clear_status_i (clearStatus),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  s;
    logic        e;
    logic [3:0]  t;
  } ment_t;

  ment_t      mq[$];
  logic [4:0] macc = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered queue of stored entries, updated on each edge from the handshake rules.
  always @(posedge clk or negedge rstN) begin
    bit         mPush, mPop;
    logic [4:0] popSt;
    if (!rstN) begin
      mq.delete();
      macc = '0;
    end else begin
      mPush = inValid && (mq.size() != DEPTH);
      mPop  = outReady && (mq.size() != 0);
      popSt = mPop ? mq[0].s : 5'b0;
      macc  = (clearStatus ? 5'b0 : macc) | popSt;
      if (flush) mq.delete();
      else begin
        if (mPop) void'(mq.pop_front());
        if (mPush) mq.push_back('{r: resultIn, s: statusIn, e: extIn, t: tagIn});
      end
    end
  end

  // Compare every DUT output with the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    ment_t head;
    head = (mq.size() != 0) ? mq[0] : '0;
    checkOutput("out_valid", 64'(outValid), 64'(mq.size() != 0));
    checkOutput("busy", 64'(busy), 64'(mq.size() != 0));
    if (rstN) checkOutput("in_ready", 64'(inReady), 64'(mq.size() != DEPTH));
    checkOutput("payload", 64'({resultOut, statusOut, extOut, tagOut}), 64'(head));
    checkOutput("status_acc", 64'(statusAcc), 64'(macc));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [4:0] s,
                               input logic [3:0] t, input logic rdy);
    inValid  = v;
    resultIn = r;
    statusIn = s;
    tagIn    = t;
    extIn    = r[0];
    outReady = rdy;
  endtask

  initial begin
    // Reset values with literal expectations.
    #12;
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_acc", 64'(statusAcc), 64'd0);
    checkOutput("rst_result", 64'(resultOut), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(inReady), 64'd1);
    @(negedge clk);

    // Single transfer of 1.0f with NX.
    applyStimulus(1, 32'h3F80_0000, 5'b00001, 4'd1, 1);
    tick();
    inValid = 0;
    checkOutput("t2_valid", 64'(outValid), 64'd1);
    checkOutput("t2_result", 64'(resultOut), 64'h3F80_0000);
    checkOutput("t2_status", 64'(statusOut), 64'd1);
    checkOutput("t2_tag", 64'(tagOut), 64'd1);
    tick();
    checkOutput("t2_acc", 64'(statusAcc), 64'd1);
    checkOutput("t2_busy", 64'(busy), 64'd0);
    clearStatus = 1;
    tick();
    clearStatus = 0;
    checkOutput("t2_clear", 64'(statusAcc), 64'd0);

    // Backpressure: a full buffer refuses C even while it pops A.
    applyStimulus(1, 32'hA, 0, 4'hA, 0);
    tick();
    applyStimulus(1, 32'hB, 0, 4'hB, 0);
    tick();
    checkOutput("t3_full", 64'(inReady), 64'd0);
    checkOutput("t3_headA", 64'(resultOut), 64'hA);
    applyStimulus(1, 32'hC, 0, 4'hC, 1);
    tick();
    checkOutput("t3_headB", 64'(resultOut), 64'hB);
    checkOutput("t3_ready", 64'(inReady), 64'd1);
    outReady = 0;
    tick();
    inValid = 0;
    checkOutput("t3_stillB", 64'(resultOut), 64'hB);
    checkOutput("t3_fullC", 64'(inReady), 64'd0);
    outReady = 1;
    tick();
    checkOutput("t3_headC", 64'(resultOut), 64'hC);
    tick();
    checkOutput("t3_empty", 64'(outValid), 64'd0);

    // Streaming: each pushed value appears one cycle later.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'(i), 0, 4'(i), 1);
      tick();
      checkOutput("t4_stream", 64'(resultOut), 64'(i));
      checkOutput("t4_ready", 64'(inReady), 64'd1);
    end
    inValid = 0;
    tick();
    checkOutput("t4_drain", 64'(busy), 64'd0);

    // Flush with OF at the head; the pop still lands in the accumulator.
    applyStimulus(1, 32'h1111, 5'b00100, 4'd2, 0);
    tick();
    applyStimulus(1, 32'h2222, 5'b00000, 4'd3, 0);
    tick();
    applyStimulus(1, 32'hDEAD, 5'b10000, 4'd4, 1);
    flush = 1;
    tick();
    flush = 0;
    inValid = 0;
    checkOutput("t5_valid", 64'(outValid), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_acc", 64'(statusAcc), 64'b00100);
    tick();
    checkOutput("t5_discard", 64'(outValid), 64'd0);

    // Clear together with a UF pop leaves only UF.
    clearStatus = 1;
    tick();
    clearStatus = 0;
    applyStimulus(1, 32'h5, 5'b10001, 4'd5, 0);
    tick();
    applyStimulus(1, 32'h6, 5'b00010, 4'd6, 1);
    tick();
    inValid = 0;
    outReady = 0;
    checkOutput("t6_pre", 64'(statusAcc), 64'b10001);
    clearStatus = 1;
    outReady = 1;
    tick();
    clearStatus = 0;
    checkOutput("t6_acc", 64'(statusAcc), 64'b00010);

    // Reset in the middle of a transfer drops stored entries at once.
    applyStimulus(1, 32'h77, 5'b00001, 4'd7, 0);
    tick();
    tick();
    inValid = 0;
    #2 rstN = 0;
    #1;
    checkOutput("rst_mid_valid", 64'(outValid), 64'd0);
    checkOutput("rst_mid_acc", 64'(statusAcc), 64'd0);
    @(negedge clk);
    rstN = 1;

    // Random traffic checked by the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)));
      flush       = ($urandom_range(0, 15) == 0);
      clearStatus = ($urandom_range(0, 11) == 0);
      tick();
    end
    flush = 0;
    clearStatus = 0;
    inValid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
